// File: rtl/branch_prediction_ctrl.sv
// Conditional-branch predictor: direct-mapped BTB with 2-bit counters for IF lookup, EX resolve/redirect and training.
// Optional perf counters are built when BP_PERF_CNT_EN is defined; otherwise BranchCnt/MispredCnt are tied to zero.
module branch_prediction_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        StallE,
  input  logic        BranchInstrE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic             valid_reg  [ENTRIES];
  logic [1:0]       ctr_reg    [ENTRIES];
  logic [TAG_W-1:0] tag_reg    [ENTRIES];
  logic [31:0]      target_reg [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;
  logic                  hit_f, hit_e, train;

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[31:INDEX_BITS+2];

  // Instruction-aligned PCs: the byte offset never participates in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Lookup reads pre-edge contents, so a same-cycle update is seen next cycle.
  assign hit_f       = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_reg[idx_f][1];
  assign PredTargetF = PredTakenF ? target_reg[idx_f] : PCF + 32'd4;

  assign MispredictE = BranchInstrE &&
                       ((BranchE != PredTakenE) ||
                        (BranchE && PredTakenE && (PredTargetE != BranchTarget)));
  assign RedirectPCE = BranchE ? BranchTarget : PCE + 32'd4;

  assign hit_e = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);
  assign train = BranchInstrE && !StallE;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic sel;
      assign sel = train && (idx_e == INDEX_BITS'(gi));

      always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
          valid_reg[gi] <= 1'b0;
          ctr_reg[gi]   <= 2'b00;
        end else if (sel) begin
          if (hit_e) begin
            if (BranchE) begin
              if (ctr_reg[gi] != 2'b11) ctr_reg[gi] <= ctr_reg[gi] + 2'd1;
            end else begin
              if (ctr_reg[gi] != 2'b00) ctr_reg[gi] <= ctr_reg[gi] - 2'd1;
            end
          end else if (BranchE) begin
            valid_reg[gi] <= 1'b1;
            ctr_reg[gi]   <= 2'b10;
          end
        end
      end

      // Tag/target carry no reset; a cleared valid bit already hides them.
      always_ff @(posedge CPU_CLK) begin
        if (sel && BranchE) begin
          tag_reg[gi]    <= tag_e;
          target_reg[gi] <= BranchTarget;
        end
      end
    end
  endgenerate

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_reg, mispred_cnt_reg;

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      branch_cnt_reg  <= 32'h0;
      mispred_cnt_reg <= 32'h0;
    end else if (train) begin
      branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (MispredictE) mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end

  assign BranchCnt  = branch_cnt_reg;
  assign MispredCnt = mispred_cnt_reg;
`else
  assign BranchCnt  = 32'h0;
  assign MispredCnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_prediction_ctrl.sv
// Directed bench for branch_prediction_ctrl: driver queues expected outputs, a negedge monitor compares them.
module tb_branch_prediction_ctrl;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b1;
  logic [31:0] PCF = 32'h0, PCE = 32'h0, BranchTarget = 32'h0, PredTargetE = 32'h0;
  logic        StallE = 1'b0, BranchInstrE = 1'b0, BranchE = 1'b0, PredTakenE = 1'b0;
  logic        PredTakenF, MispredictE;
  logic [31:0] PredTargetF, RedirectPCE, BranchCnt, MispredCnt;

  branch_prediction_ctrl #(.INDEX_BITS(6)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PCF(PCF), .PCE(PCE), .StallE(StallE),
    .BranchInstrE(BranchInstrE), .BranchE(BranchE), .BranchTarget(BranchTarget),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  typedef enum int { K_PTF, K_PTGT, K_MIS, K_RPC, K_BCNT, K_MCNT } kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef BP_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic expect_out(input string name, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = k; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic ptf, input logic [31:0] ptgt);
    PCF = pc;
    expect_out({tag, "_ptf"}, K_PTF, {31'h0, ptf});
    expect_out({tag, "_ptgt"}, K_PTGT, ptgt);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pce, input logic br,
                         input logic [31:0] btgt, input logic ptk, input logic [31:0] ptgt,
                         input logic stall, input logic mis, input logic [31:0] rpc);
    PCE = pce; BranchInstrE = 1'b1; BranchE = br; BranchTarget = btgt;
    PredTakenE = ptk; PredTargetE = ptgt; StallE = stall;
    expect_out({tag, "_mis"}, K_MIS, {31'h0, mis});
    expect_out({tag, "_rpc"}, K_RPC, rpc);
  endtask

  task automatic counters(input string tag, input logic [31:0] b, input logic [31:0] m);
    expect_out({tag, "_bcnt"}, K_BCNT, cnt(b));
    expect_out({tag, "_mcnt"}, K_MCNT, cnt(m));
  endtask

  task automatic idle();
    BranchInstrE = 1'b0; StallE = 1'b0;
  endtask

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
  initial begin
    forever begin
      @(negedge CPU_CLK);
      while (sb_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb_q.pop_front();
        case (e.kind)
          K_PTF:   act = {31'h0, PredTakenF};
          K_PTGT:  act = PredTargetF;
          K_MIS:   act = {31'h0, MispredictE};
          K_RPC:   act = RedirectPCE;
          K_BCNT:  act = BranchCnt;
          default: act = MispredCnt;
        endcase
        n_checks++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        $display("check %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #12;
    CPU_RST = 1'b0;
    step();

    lookup("rst", 32'h100, 1'b0, 32'h104);
    expect_out("rst_mis", K_MIS, 32'h0);
    counters("rst", 0, 0);
    step();

    // Allocate 0x200 -> 0x180; same-cycle lookup still misses.
    resolve("alloc", 32'h200, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b1, 32'h180);
    lookup("alloc_same", 32'h200, 1'b0, 32'h204);
    step();
    idle();
    lookup("alloc_next", 32'h200, 1'b1, 32'h180);
    counters("alloc", 1, 1);
    step();

    resolve("nt1", 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 1'b0, 1'b1, 32'h204);
    step();
    resolve("nt2", 32'h200, 1'b0, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204);
    step();
    idle();
    BranchE = 1'b1; PredTakenE = 1'b0;
    expect_out("nobr_mis", K_MIS, 32'h0);
    lookup("weak_nt", 32'h200, 1'b0, 32'h204);
    step();

    // Correct taken (ctr 00->01) then target change (ctr 01->10, target 0x1C0).
    resolve("tk_ok", 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0, 32'h180);
    step();
    resolve("tgt_chg", 32'h200, 1'b1, 32'h1C0, 1'b1, 32'h180, 1'b0, 1'b1, 32'h1C0);
    step();
    idle();
    lookup("tgt_new", 32'h200, 1'b1, 32'h1C0);
    step();

    resolve("alias", 32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 1'b0, 1'b1, 32'h380);
    step();
    idle();
    lookup("alias_200", 32'h200, 1'b0, 32'h204);
    step();
    lookup("alias_300", 32'h300, 1'b1, 32'h380);
    counters("seq", 6, 4);
    step();

    resolve("stall", 32'h200, 1'b1, 32'h1C0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C0);
    step();
    idle();
    lookup("stall_200", 32'h200, 1'b0, 32'h204);
    counters("stall", 6, 4);
    step();

    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    step();

    // Saturation: three correct taken at 0x300 leave ctr at 11; one not-taken drops to 10.
    for (int i = 0; i < 3; i++) begin
      resolve("sat_tk", 32'h300, 1'b1, 32'h380, 1'b1, 32'h380, 1'b0, 1'b0, 32'h380);
      step();
    end
    resolve("sat_nt", 32'h300, 1'b0, 32'h380, 1'b1, 32'h380, 1'b0, 1'b1, 32'h304);
    step();
    idle();
    lookup("sat_300", 32'h300, 1'b1, 32'h380);
    counters("sat", 10, 5);
    step();

    // Asynchronous reset mid-cycle: checked at the following negedge, before any clock edge.
    CPU_RST = 1'b1;
    resolve("inrst", 32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 1'b0, 1'b1, 32'h380);
    lookup("inrst", 32'h300, 1'b0, 32'h304);
    counters("inrst", 0, 0);
    step();
    idle();
    CPU_RST = 1'b0;
    lookup("postrst", 32'h200, 1'b0, 32'h204);
    step();

    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
